// File: rtl/q_sys_batch_pkg.sv
// Shared types and constants for the q_sys batch sequencer: FSM states,
// register addresses and status/control bit positions.
package q_sys_batch_pkg;

  localparam int unsigned BATW = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;

  localparam int unsigned STAT_BUSY_BIT  = 31;
  localparam int unsigned STAT_DONE_BIT  = 30;
  localparam int unsigned STAT_ERR_BIT   = 29;

  localparam int unsigned CTRL_ABORT_BIT = 0;
  localparam int unsigned CTRL_CLR_BIT   = 1;

endpackage

// File: rtl/q_sys_batch_watchdog.sv
// Free-running handshake watchdog: clears on clr, counts while en, and flags
// the cycle whose edge would bring the count up to LIMIT.
module q_sys_batch_watchdog #(
  parameter int unsigned      TMOW  = 16,
  parameter logic [TMOW-1:0]  LIMIT = '1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TMOW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + TMOW'(1);
    end
  end

  // Decoded one cycle early so the owner acts on the edge that reaches LIMIT.
  assign expired = (count == (LIMIT - TMOW'(1)));

endmodule

// File: rtl/q_sys_batch_sequencer.sv
// Batch sequencer: latches a batch count on start, issues one eng_start per
// batch, waits on eng_done with a watchdog, and exposes status over Avalon-MM.
module q_sys_batch_sequencer #(
  parameter int unsigned     BATW    = q_sys_batch_pkg::BATW,
  parameter int unsigned     TMOW    = 16,
  parameter logic [TMOW-1:0] TMO_CYC = TMOW'(16'hFFFF)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [BATW-1:0] batnum,
  input  logic            start,
  output logic            eng_start,
  output logic [BATW-1:0] eng_batch_idx,
  input  logic            eng_done,
  output logic            busy,
  input  logic [1:0]      address,
  input  logic            chipselect,
  input  logic            write_n,
  input  logic [31:0]     writedata,
  output logic [31:0]     readdata
);

  import q_sys_batch_pkg::*;

  state_t          state, state_nxt;
  logic [BATW-1:0] len, len_nxt;
  logic [BATW-1:0] idx, idx_nxt;
  logic [BATW-1:0] cnt, cnt_nxt;
  logic [BATW-1:0] idx_inc;
  logic            done, done_nxt;
  logic            err, err_nxt;
  logic            busy_nxt;
  logic            eng_start_nxt;
  logic            wd_clr, wd_en, wd_expired;
  logic            ctrl_wr, abort_wr, clr_wr;
  logic            unused_writedata;

  assign ctrl_wr          = chipselect && !write_n && (address == ADDR_CTRL);
  assign abort_wr         = ctrl_wr && writedata[CTRL_ABORT_BIT];
  assign clr_wr           = ctrl_wr && writedata[CTRL_CLR_BIT];
  assign unused_writedata = ^writedata[31:2];

  assign idx_inc       = idx + BATW'(1);
  assign eng_batch_idx = idx;

  q_sys_batch_watchdog #(
    .TMOW  (TMOW),
    .LIMIT (TMO_CYC)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      len       <= '0;
      idx       <= '0;
      cnt       <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      eng_start <= 1'b0;
    end else begin
      state     <= state_nxt;
      len       <= len_nxt;
      idx       <= idx_nxt;
      cnt       <= cnt_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
      busy      <= busy_nxt;
      eng_start <= eng_start_nxt;
    end
  end

  // Next-state logic; abort outranks everything, eng_done outranks timeout.
  always_comb begin
    state_nxt = state;
    len_nxt   = len;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    done_nxt  = done;
    err_nxt   = err;
    busy_nxt  = busy;
    wd_clr    = 1'b0;
    wd_en     = 1'b0;

    if (clr_wr) begin
      done_nxt = 1'b0;
      err_nxt  = 1'b0;
    end

    if (abort_wr) begin
      state_nxt = ST_IDLE;
      busy_nxt  = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // busy in IDLE only happens after a zero-length start.
          if (busy) begin
            done_nxt = 1'b1;
            busy_nxt = 1'b0;
          end else if (start) begin
            len_nxt  = batnum;
            idx_nxt  = '0;
            cnt_nxt  = '0;
            done_nxt = 1'b0;
            err_nxt  = 1'b0;
            busy_nxt = 1'b1;
            if (batnum != '0) state_nxt = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wd_clr    = 1'b1;
          state_nxt = ST_WAIT;
        end
        ST_WAIT: begin
          wd_en = 1'b1;
          if (eng_done) begin
            cnt_nxt = cnt + BATW'(1);
            if (idx_inc == len) begin
              done_nxt  = 1'b1;
              busy_nxt  = 1'b0;
              state_nxt = ST_IDLE;
            end else begin
              idx_nxt   = idx_inc;
              state_nxt = ST_ISSUE;
            end
          end else if (wd_expired) begin
            err_nxt   = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end

    eng_start_nxt = (state_nxt == ST_ISSUE);
  end

  // Zero-wait-state register read mux.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_STATUS: begin
        readdata[STAT_BUSY_BIT] = busy;
        readdata[STAT_DONE_BIT] = done;
        readdata[STAT_ERR_BIT]  = err;
        readdata[BATW-1:0]      = cnt;
      end
      ADDR_CTRL: readdata[BATW-1:0] = len;
      default: readdata = '0;
    endcase
  end

endmodule
